// File: rtl/byte_frame_loader.sv
// Stream-to-memory frame loader: writes DEPTH bytes into the pack FSM, kicks it, waits for done.
// Define BYTE_FRAME_LOADER_PAD_EN to zero-fill frames cut short by s_last.
module byte_frame_loader #(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  input  logic          s_last,
  output logic          s_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_add,
  output logic [7:0]    data_wr,
  output logic          op_mode,
  input  logic          done,
  output logic          busy,
  output logic          frame_done,
  output logic          err_timeout
);

  localparam int            WW          = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);
  localparam logic [WW-1:0] TIMEOUT_PRE = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] TIMEOUT_MAX = WW'(TIMEOUT);

  typedef enum logic [1:0] {LOAD, PAD, KICK, WAIT} state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic [WW-1:0] wait_cnt;
  logic          accept;

  assign s_ready = (state == LOAD);
  assign busy    = (state != LOAD);
  assign accept  = s_valid & s_ready;

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // read in this block sees the value from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      cnt         <= '0;
      wait_cnt    <= '0;
      wr_en       <= 1'b0;
      wr_add      <= '0;
      data_wr     <= '0;
      op_mode     <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      // NOTE: strobes default low here, so each one is a single-cycle pulse
      // unless a branch below re-asserts it.
      wr_en      <= 1'b0;
      op_mode    <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        LOAD: begin
          if (accept) begin
            wr_en   <= 1'b1;
            wr_add  <= cnt;
            data_wr <= s_data;
            cnt     <= cnt + 1'b1;
            // A full frame wins over s_last on its final byte.
            if (cnt == LAST_ADDR) begin
              state <= KICK;
            end else if (s_last) begin
`ifdef BYTE_FRAME_LOADER_PAD_EN
              state <= PAD;
`else
              state <= KICK;
`endif
            end
          end
        end

`ifdef BYTE_FRAME_LOADER_PAD_EN
        PAD: begin
          wr_en   <= 1'b1;
          wr_add  <= cnt;
          data_wr <= '0;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_ADDR) state <= KICK;
        end
`endif

        KICK: begin
          op_mode  <= 1'b1;
          wait_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          if (wait_cnt != TIMEOUT_MAX) wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == TIMEOUT_PRE) err_timeout <= 1'b1;
          // wait_cnt == 0 marks the op_mode cycle, where done may still be stale.
          if (wait_cnt != '0 && done) begin
            frame_done <= 1'b1;
            cnt        <= '0;
            state      <= LOAD;
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_frame_loader.sv
// Self-checking bench for byte_frame_loader: a timeline model schedules the expected
// output of every cycle from the frame timing rules, and a negedge process compares.
module tb_byte_frame_loader;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int TMO   = 255;
  localparam int N     = 4096;
  localparam int BIG   = 1 << 30;
`ifdef BYTE_FRAME_LOADER_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_add;
  logic [7:0]    data_wr;
  logic          op_mode;
  logic          done;
  logic          busy;
  logic          frame_done;
  logic          err_timeout;

  byte_frame_loader #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .wr_en(wr_en), .wr_add(wr_add), .data_wr(data_wr),
    .op_mode(op_mode), .done(done), .busy(busy), .frame_done(frame_done),
    .err_timeout(err_timeout)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  bit stale = 1'b0;

  // Expected outputs per cycle index, filled ahead of time by the stimulus tasks.
  logic          e_wr[N];
  logic [AW-1:0] e_addr[N];
  logic [7:0]    e_data[N];
  logic          e_op[N];
  logic          e_fd[N];
  logic          e_busy[N];
  logic          e_rst[N];
  int            err_rise = BIG;
  int            err_clr  = BIG;

  // ref_mem is what the pack FSM should hold; fsm_mem is built from the DUT's writes.
  logic [7:0]    ref_mem[DEPTH];
  logic [7:0]    fsm_mem[DEPTH];
  logic [AW-1:0] h_addr;
  logic [7:0]    h_data;
  int            op_seen  = -1;
  int            fd_seen  = -1;
  int            err_seen = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int c;
    if (chk_on) begin
      c = cyc;
      if (c >= N - 4) begin
        $display("FAIL watchdog @cycle %0d: got no end, expected finish below %0d", c, N - 4);
        $fatal(1, "cycle budget exhausted");
      end
      if (e_rst[c]) begin
        h_addr = '0;
        h_data = '0;
      end
      if (e_wr[c]) begin
        h_addr = e_addr[c];
        h_data = e_data[c];
      end
      check("wr_en",       32'(wr_en),       32'(e_wr[c]));
      check("wr_add",      32'(wr_add),      32'(h_addr));
      check("data_wr",     32'(data_wr),     32'(h_data));
      check("op_mode",     32'(op_mode),     32'(e_op[c]));
      check("frame_done",  32'(frame_done),  32'(e_fd[c]));
      check("busy",        32'(busy),        32'(e_busy[c]));
      check("s_ready",     32'(s_ready),     32'(!e_busy[c]));
      check("err_timeout", 32'(err_timeout), 32'(c >= err_rise && c < err_clr));
      if (wr_en) fsm_mem[wr_add] = data_wr;
      if (op_mode) op_seen = c;
      if (frame_done) fd_seen = c;
      if (err_timeout && err_seen < 0) err_seen = c;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present n bytes; gap 0 = back-to-back, 1 = every other cycle, 2 = random.
  task automatic feed(input int n, input bit with_last, input int gap, input bit data_rand,
                      output int c_last);
    int pos = 0;
    bit alt = 1'b0;
    bit v;
    logic [7:0] b;
    c_last = cyc;
    while (pos < n) begin
      case (gap)
        0:       v = 1'b1;
        1:       begin v = alt; alt = ~alt; end
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      if (v) begin
        b = data_rand ? 8'($urandom) : 8'(2 * pos + 1);
        s_valid = 1'b1;
        s_data  = b;
        s_last  = with_last && (pos == n - 1);
        e_wr[cyc + 1]   = 1'b1;
        e_addr[cyc + 1] = AW'(pos);
        e_data[cyc + 1] = b;
        ref_mem[pos]    = b;
        c_last = cyc;
        pos++;
      end else begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
      end
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // One whole frame: load, optional pad, kick, done after done_dly extra cycles.
  task automatic run_frame(input int n, input bit with_last, input int gap, input int done_dly,
                           input bit data_rand, output int c_last);
    int w, lw, o, f;
    feed(n, with_last, gap, data_rand, c_last);
    w  = cyc;
    lw = w;
    if (PAD_EN && n < DEPTH) begin
      for (int a = n; a < DEPTH; a++) begin
        lw++;
        e_wr[lw]   = 1'b1;
        e_addr[lw] = AW'(a);
        e_data[lw] = '0;
        ref_mem[a] = '0;
      end
    end
    o = lw + 1;
    e_op[o] = 1'b1;
    f = o + 2 + done_dly;
    e_fd[f] = 1'b1;
    for (int c = w; c < f; c++) e_busy[c] = 1'b1;
    if (f >= o + TMO && err_rise == BIG) err_rise = o + TMO;
    while (cyc < f) begin
      if (cyc == o + 1 + done_dly) done = 1'b1;
      s_valid = 1'($urandom);
      s_data  = 8'($urandom);
      s_last  = 1'($urandom);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!stale) done = 1'b0;
    tick();
    for (int i = 0; i < DEPTH / 2; i++)
      check("packed_word", 32'({fsm_mem[2*i], fsm_mem[2*i+1]}), 32'({ref_mem[2*i], ref_mem[2*i+1]}));
  endtask

  int cl;
  int n_r;
  bit wl_r;

  initial begin
    for (int i = 0; i < N; i++) begin
      e_wr[i] = 1'b0; e_addr[i] = '0; e_data[i] = '0;
      e_op[i] = 1'b0; e_fd[i] = 1'b0; e_busy[i] = 1'b0; e_rst[i] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      fsm_mem[i] = '0;
    end
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; done = 1'b0;
    tick();
    tick();
    e_rst[cyc] = 1'b1;
    chk_on = 1'b1;
    rst = 1'b0;
    tick();

    // Full frame of 2i+1, back-to-back.
    run_frame(32, 1'b0, 0, 0, 1'b0, cl);
    check("op_after_last_byte", 32'(op_seen - cl), 32'd2);
    check("op_to_frame_done",   32'(fd_seen - op_seen), 32'd2);
    check("word0_full",  32'({fsm_mem[0], fsm_mem[1]}),   32'h0103);
    check("word15_full", 32'({fsm_mem[30], fsm_mem[31]}), 32'h3D3F);

    // Same data with s_valid low every other cycle.
    run_frame(32, 1'b0, 1, 2, 1'b0, cl);
    check("op_after_last_byte_bp", 32'(op_seen - cl), 32'd2);
    check("op_to_frame_done_bp",   32'(fd_seen - op_seen), 32'd4);
    check("word7_bp", 32'({fsm_mem[14], fsm_mem[15]}), 32'h1D1F);

    // Short frame: s_last on byte 10 (addr 9).
    run_frame(10, 1'b1, 0, 1, 1'b0, cl);
    check("op_after_short", 32'(op_seen - cl), PAD_EN ? 32'd24 : 32'd2);
    check("word4_short",  32'({fsm_mem[8], fsm_mem[9]}),   32'h1113);
    check("word5_short",  32'({fsm_mem[10], fsm_mem[11]}), PAD_EN ? 32'h0000 : 32'h1517);
    check("word15_short", 32'({fsm_mem[30], fsm_mem[31]}), PAD_EN ? 32'h0000 : 32'h3D3F);

    // done held high across the frame; s_last on the 32nd byte must be ignored.
    stale = 1'b1;
    done  = 1'b1;
    run_frame(32, 1'b1, 2, 0, 1'b1, cl);
    check("stale_done_delay", 32'(fd_seen - op_seen), 32'd2);
    stale = 1'b0;
    done  = 1'b0;

    // done withheld past the timeout, then given.
    run_frame(32, 1'b0, 0, TMO + 5, 1'b1, cl);
    check("timeout_delay",     32'(err_seen - op_seen), 32'(TMO));
    check("late_done_delay",   32'(fd_seen - op_seen),  32'(TMO + 7));
    check("err_after_timeout", 32'(err_timeout), 32'd1);

    // Random frames of random length, gaps and done latency.
    repeat (8) begin
      n_r  = $urandom_range(1, DEPTH);
      wl_r = (n_r < DEPTH) ? 1'b1 : 1'($urandom);
      run_frame(n_r, wl_r, $urandom_range(0, 2), $urandom_range(0, 6), 1'b1, cl);
    end
    check("err_sticky", 32'(err_timeout), 32'd1);

    // Reset after 17 bytes of a frame.
    feed(17, 1'b0, 0, 1'b1, cl);
    rst = 1'b1;
    e_rst[cyc + 1] = 1'b1;
    err_clr = cyc + 1;
    tick();
    rst = 1'b0;
    check("rst_wr_en",   32'(wr_en),       32'd0);
    check("rst_op_mode", 32'(op_mode),     32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_s_ready", 32'(s_ready),     32'd1);
    check("rst_err",     32'(err_timeout), 32'd0);
    tick();
    run_frame(32, 1'b0, 0, 3, 1'b1, cl);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
